// File: rtl/led_blink_driver_if.sv
// Command/status bundle between a controller and led_blink_driver.
// BLINK_ABORT_EN adds the i_Abort request line.
interface led_blink_driver_if #(
  parameter int COUNT_WIDTH = 4
);
  logic                   i_Start;
  logic [COUNT_WIDTH-1:0] i_Count;
  logic                   o_LED;
  logic                   o_Busy;
  logic                   o_Done;
`ifdef BLINK_ABORT_EN
  logic                   i_Abort;

  modport master (output i_Start, i_Count, i_Abort, input  o_LED, o_Busy, o_Done);
  modport slave  (input  i_Start, i_Count, i_Abort, output o_LED, o_Busy, o_Done);
`else
  modport master (output i_Start, i_Count, input  o_LED, o_Busy, o_Done);
  modport slave  (input  i_Start, i_Count, output o_LED, o_Busy, o_Done);
`endif
endinterface

// File: rtl/led_blink_driver.sv
// Blinks one LED i_Count times with ON_CYCLES/OFF_CYCLES periods, then pulses o_Done.
// Optional BLINK_ABORT_EN: i_Abort cancels a running sequence without o_Done.
module led_blink_driver #(
  parameter int ON_CYCLES   = 12500000,
  parameter int OFF_CYCLES  = 12500000,
  parameter int COUNT_WIDTH = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  led_blink_driver_if.slave  bus
);
  localparam int MAXP = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = $clog2(MAXP + 1);
  localparam logic [CW-1:0]          ON_LOAD  = CW'(ON_CYCLES);
  localparam logic [CW-1:0]          OFF_LOAD = CW'(OFF_CYCLES);
  localparam logic [CW-1:0]          PER_ONE  = CW'(1);
  localparam logic [COUNT_WIDTH-1:0] REM_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          per_q, per_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic                   led_q, busy_q, done_q;
  logic                   abort;

`ifdef BLINK_ABORT_EN
  assign abort = bus.i_Abort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.i_Start) begin
          rem_d = bus.i_Count;
          if (bus.i_Count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ON;
            per_d   = ON_LOAD;
          end
        end
      end
      S_ON: begin
        if (abort) begin
          state_d = S_IDLE;
          per_d   = '0;
          rem_d   = '0;
        end else if (per_q == PER_ONE) begin
          state_d = S_OFF;
          per_d   = OFF_LOAD;
        end else begin
          per_d = per_q - PER_ONE;
        end
      end
      S_OFF: begin
        if (abort) begin
          state_d = S_IDLE;
          per_d   = '0;
          rem_d   = '0;
        end else if (per_q == PER_ONE) begin
          // End of one full blink: either finish or relaunch the ON phase.
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = S_DONE;
            per_d   = '0;
          end else begin
            state_d = S_ON;
            per_d   = ON_LOAD;
          end
        end else begin
          per_d = per_q - PER_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they change exactly with state_q.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      rem_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      led_q   <= (state_d == S_ON);
      busy_q  <= (state_d == S_ON) || (state_d == S_OFF);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.o_LED  = led_q;
  assign bus.o_Busy = busy_q;
  assign bus.o_Done = done_q;
endmodule
